// File: rtl/bus_rr_xbar_if.sv
// Host/device/config signal bundle for bus_rr_xbar.
// slave: crossbar view; master: hosts, devices and configuration side.
interface bus_rr_xbar_if #(
  parameter int unsigned Hosts        = 2,
  parameter int unsigned Devices      = 4,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
);
  logic [Hosts-1:0]        h_req_in;
  logic [Hosts-1:0]        h_gnt_out;
  logic [AddressWidth-1:0] h_addr_in   [Hosts];
  logic [Hosts-1:0]        h_we_in;
  logic [DataWidth-1:0]    h_wdata_in  [Hosts];
  logic [Hosts-1:0]        h_rvalid_out;
  logic [DataWidth-1:0]    h_rdata_out [Hosts];
  logic [Hosts-1:0]        h_err_out;

  logic [Devices-1:0]      d_req_out;
  logic [AddressWidth-1:0] d_addr_out  [Devices];
  logic [Devices-1:0]      d_we_out;
  logic [DataWidth-1:0]    d_wdata_out [Devices];
  logic [DataWidth-1:0]    d_rdata_in  [Devices];

  logic [AddressWidth-1:0] cfg_device_addr_base [Devices];
  logic [AddressWidth-1:0] cfg_device_addr_mask [Devices];

  modport slave (
    input  h_req_in, h_addr_in, h_we_in, h_wdata_in, d_rdata_in,
           cfg_device_addr_base, cfg_device_addr_mask,
    output h_gnt_out, h_rvalid_out, h_rdata_out, h_err_out,
           d_req_out, d_addr_out, d_we_out, d_wdata_out
  );

  modport master (
    output h_req_in, h_addr_in, h_we_in, h_wdata_in, d_rdata_in,
           cfg_device_addr_base, cfg_device_addr_mask,
    input  h_gnt_out, h_rvalid_out, h_rdata_out, h_err_out,
           d_req_out, d_addr_out, d_we_out, d_wdata_out
  );
endinterface

// File: rtl/bus_rr_xbar.sv
// Round-robin shared bus: N hosts to M address-mapped devices, one transfer per cycle,
// response one cycle after grant. Define BUS_DECODE_ERR_EN to report decode misses as errors.
module bus_rr_xbar #(
  parameter int unsigned Hosts        = 2,
  parameter int unsigned Devices      = 4,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic         clk_in,
  input  logic         reset_n_in,
  bus_rr_xbar_if.slave bus
);

  localparam int unsigned PtrW = (Hosts   > 1) ? $clog2(Hosts)   : 1;
  localparam int unsigned DevW = (Devices > 1) ? $clog2(Devices) : 1;

  logic [PtrW-1:0] rr_ptr;
  logic            resp_valid;
  logic [PtrW-1:0] resp_host;
  logic [DevW-1:0] resp_dev;
  logic            resp_we;
  logic            resp_err;

  logic            found;
  logic [PtrW-1:0] winner;
  int unsigned     cand;
  logic            grant_c;
  logic            miss_c;
  logic            dec_err_c;
  logic            dev_fire_c;
  logic [DevW-1:0] dev_sel;
  logic [AddressWidth-1:0] win_addr;

  // Round-robin scan starting at rr_ptr, wrapping modulo Hosts.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int unsigned i = 0; i < Hosts; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= Hosts) cand = cand - Hosts;
      if (!found && bus.h_req_in[PtrW'(cand)]) begin
        found  = 1'b1;
        winner = PtrW'(cand);
      end
    end
  end

  // Outputs are forced quiet while reset is held, even with requests pending.
  assign grant_c  = found & reset_n_in;
  assign win_addr = bus.h_addr_in[winner];

  // Address decode on the winner; lowest matching device index takes priority.
  always_comb begin
    miss_c  = 1'b1;
    dev_sel = '0;
    for (int unsigned d = 0; d < Devices; d++) begin
      if (miss_c &&
          ((win_addr & bus.cfg_device_addr_mask[DevW'(d)]) == bus.cfg_device_addr_base[DevW'(d)])) begin
        miss_c  = 1'b0;
        dev_sel = DevW'(d);
      end
    end
  end

`ifdef BUS_DECODE_ERR_EN
  assign dec_err_c = miss_c;
`else
  // Without error reporting a miss simply falls through to device 0 (dev_sel default).
  assign dec_err_c = 1'b0;
`endif

  assign dev_fire_c = grant_c & ~dec_err_c;

  // Grant vector and forwarded request to the selected device.
  always_comb begin
    for (int unsigned h = 0; h < Hosts; h++) begin
      bus.h_gnt_out[PtrW'(h)] = grant_c && (winner == PtrW'(h));
    end
    for (int unsigned d = 0; d < Devices; d++) begin
      bus.d_req_out[DevW'(d)]   = 1'b0;
      bus.d_addr_out[DevW'(d)]  = '0;
      bus.d_we_out[DevW'(d)]    = 1'b0;
      bus.d_wdata_out[DevW'(d)] = '0;
      if (dev_fire_c && (dev_sel == DevW'(d))) begin
        bus.d_req_out[DevW'(d)]   = 1'b1;
        bus.d_addr_out[DevW'(d)]  = win_addr;
        bus.d_we_out[DevW'(d)]    = bus.h_we_in[winner];
        bus.d_wdata_out[DevW'(d)] = bus.h_wdata_in[winner];
      end
    end
  end

  // Pointer and one-deep response pipeline; reset discards any pending response.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      rr_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_host  <= '0;
      resp_dev   <= '0;
      resp_we    <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= grant_c;
      if (grant_c) begin
        rr_ptr    <= (winner == PtrW'(Hosts - 1)) ? '0 : PtrW'(winner + 1'b1);
        resp_host <= winner;
        resp_dev  <= dev_sel;
        resp_we   <= bus.h_we_in[winner];
        resp_err  <= dec_err_c;
      end
    end
  end

  // Response steering: read data is live from the device, zero for writes and errors.
  always_comb begin
    for (int unsigned h = 0; h < Hosts; h++) begin
      bus.h_rvalid_out[PtrW'(h)] = 1'b0;
      bus.h_err_out[PtrW'(h)]    = 1'b0;
      bus.h_rdata_out[PtrW'(h)]  = '0;
      if (resp_valid && (resp_host == PtrW'(h))) begin
        bus.h_rvalid_out[PtrW'(h)] = 1'b1;
        bus.h_err_out[PtrW'(h)]    = resp_err;
        if (!resp_we && !resp_err) begin
          bus.h_rdata_out[PtrW'(h)] = bus.d_rdata_in[resp_dev];
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_rr_xbar.sv
// Directed bench for bus_rr_xbar with three hosts and four devices.
module tb_bus_rr_xbar;

  localparam int unsigned Hosts = 3;
  localparam int unsigned Devices = 4;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned AddressWidth = 32;

  logic clk_in = 1'b0;
  logic reset_n_in;
  int   n_checks = 0;
  int   n_fail = 0;

  bus_rr_xbar_if #(.Hosts(Hosts), .Devices(Devices), .DataWidth(DataWidth),
                   .AddressWidth(AddressWidth)) bus ();

  bus_rr_xbar #(.Hosts(Hosts), .Devices(Devices), .DataWidth(DataWidth),
                .AddressWidth(AddressWidth)) dut (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .bus        (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Map: dev0 0x2xxx_xxxx, dev1 0x1xxx_xxxx, dev2 0x3xxx_xxxx, dev3 0x2000_xxxx (overlaps dev0).
    bus.cfg_device_addr_base[0] = 32'h2000_0000; bus.cfg_device_addr_mask[0] = 32'hF000_0000;
    bus.cfg_device_addr_base[1] = 32'h1000_0000; bus.cfg_device_addr_mask[1] = 32'hF000_0000;
    bus.cfg_device_addr_base[2] = 32'h3000_0000; bus.cfg_device_addr_mask[2] = 32'hF000_0000;
    bus.cfg_device_addr_base[3] = 32'h2000_0000; bus.cfg_device_addr_mask[3] = 32'hFFFF_0000;
    for (int d = 0; d < 4; d++) bus.d_rdata_in[d] = 32'h0;
    bus.d_rdata_in[0] = 32'hDEAD_BEEF;
    for (int h = 0; h < 3; h++) begin
      bus.h_addr_in[h]  = 32'h1000_0000;
      bus.h_wdata_in[h] = 32'h0;
    end
    bus.h_we_in  = 3'b000;
    bus.h_req_in = 3'b111;
    reset_n_in   = 1'b0;

    // Reset: requests pending but nothing may be granted or forwarded.
    #1;
    chk("reset_gnt", 64'(bus.h_gnt_out), 64'h0);
    chk("reset_dreq", 64'(bus.d_req_out), 64'h0);
    chk("reset_rvalid", 64'(bus.h_rvalid_out), 64'h0);
    chk("reset_err", 64'(bus.h_err_out), 64'h0);
    @(negedge clk_in);
    reset_n_in = 1'b1;

    // Round robin with all hosts requesting: 0,1,2,0,1,2.
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_gnt", 64'(bus.h_gnt_out), 64'(3'b001 << (k % 3)));
      chk("rr_dreq", 64'(bus.d_req_out), 64'h2);
      if (k > 0) chk("rr_rvalid", 64'(bus.h_rvalid_out), 64'(3'b001 << ((k - 1) % 3)));
      @(negedge clk_in);
    end
    bus.h_req_in = 3'b000;
    #1;
    chk("rr_last_rvalid", 64'(bus.h_rvalid_out), 64'h4);
    chk("idle_gnt", 64'(bus.h_gnt_out), 64'h0);
    @(negedge clk_in);

    // Read path: host1 reads dev1.
    bus.h_req_in = 3'b010;
    bus.h_addr_in[1] = 32'h1000_0004;
    #1;
    chk("rd_gnt", 64'(bus.h_gnt_out), 64'h2);
    chk("rd_dreq", 64'(bus.d_req_out), 64'h2);
    chk("rd_daddr1", 64'(bus.d_addr_out[1]), 64'h1000_0004);
    chk("rd_daddr0", 64'(bus.d_addr_out[0]), 64'h0);
    chk("rd_dwe1", 64'(bus.d_we_out[1]), 64'h0);
    @(negedge clk_in);
    bus.h_req_in = 3'b000;
    bus.d_rdata_in[1] = 32'hCAFE_F00D;
    #1;
    chk("rd_rvalid", 64'(bus.h_rvalid_out), 64'h2);
    chk("rd_rdata1", 64'(bus.h_rdata_out[1]), 64'hCAFE_F00D);
    chk("rd_rdata0", 64'(bus.h_rdata_out[0]), 64'h0);
    chk("rd_rdata2", 64'(bus.h_rdata_out[2]), 64'h0);
    chk("rd_err", 64'(bus.h_err_out), 64'h0);
    @(negedge clk_in);

    // Write then overlapping read: rr_ptr is 2, so the lone host0 request wins.
    bus.h_req_in = 3'b001;
    bus.h_addr_in[0] = 32'h2100_0000;
    bus.h_we_in = 3'b001;
    bus.h_wdata_in[0] = 32'h55;
    #1;
    chk("wr_gnt", 64'(bus.h_gnt_out), 64'h1);
    chk("wr_dreq", 64'(bus.d_req_out), 64'h1);
    chk("wr_dwe0", 64'(bus.d_we_out), 64'h1);
    chk("wr_dwdata0", 64'(bus.d_wdata_out[0]), 64'h55);
    @(negedge clk_in);
    bus.h_req_in = 3'b010;
    bus.h_we_in = 3'b000;
    bus.h_addr_in[1] = 32'h3000_0008;
    bus.d_rdata_in[2] = 32'h1234_5678;
    #1;
    chk("ov_rvalid_wr", 64'(bus.h_rvalid_out), 64'h1);
    chk("ov_rdata_wr", 64'(bus.h_rdata_out[0]), 64'h0);
    chk("ov_gnt", 64'(bus.h_gnt_out), 64'h2);
    chk("ov_dreq", 64'(bus.d_req_out), 64'h4);
    chk("ov_daddr2", 64'(bus.d_addr_out[2]), 64'h3000_0008);
    @(negedge clk_in);
    bus.h_req_in = 3'b000;
    #1;
    chk("ov_rvalid_rd", 64'(bus.h_rvalid_out), 64'h2);
    chk("ov_rdata_rd", 64'(bus.h_rdata_out[1]), 64'h1234_5678);
    @(negedge clk_in);

    // Overlapping decode: dev0 and dev3 both hit, dev0 must win; rr_ptr=2 so host2 wins.
    bus.h_req_in = 3'b100;
    bus.h_addr_in[2] = 32'h2000_0000;
    #1;
    chk("dup_gnt", 64'(bus.h_gnt_out), 64'h4);
    chk("dup_dreq", 64'(bus.d_req_out), 64'h1);
    @(negedge clk_in);
    bus.h_req_in = 3'b000;
    #1;
    chk("dup_rvalid", 64'(bus.h_rvalid_out), 64'h4);
    chk("dup_rdata", 64'(bus.h_rdata_out[2]), 64'hDEAD_BEEF);
    @(negedge clk_in);

    // Decode miss from host0 (rr_ptr=0).
    bus.h_req_in = 3'b001;
    bus.h_addr_in[0] = 32'hFFFF_0000;
    #1;
    chk("miss_gnt", 64'(bus.h_gnt_out), 64'h1);
`ifdef BUS_DECODE_ERR_EN
    chk("miss_dreq", 64'(bus.d_req_out), 64'h0);
`else
    chk("miss_dreq", 64'(bus.d_req_out), 64'h1);
    chk("miss_daddr0", 64'(bus.d_addr_out[0]), 64'hFFFF_0000);
`endif
    @(negedge clk_in);
    bus.h_req_in = 3'b000;
    #1;
    chk("miss_rvalid", 64'(bus.h_rvalid_out), 64'h1);
`ifdef BUS_DECODE_ERR_EN
    chk("miss_err", 64'(bus.h_err_out), 64'h1);
    chk("miss_rdata", 64'(bus.h_rdata_out[0]), 64'h0);
`else
    chk("miss_err", 64'(bus.h_err_out), 64'h0);
    chk("miss_rdata", 64'(bus.h_rdata_out[0]), 64'hDEAD_BEEF);
`endif
    @(negedge clk_in);

    // Reset mid-stream with a response pending and rr_ptr away from 0.
    bus.h_req_in = 3'b110;
    bus.h_addr_in[1] = 32'h1000_0000;
    bus.h_addr_in[2] = 32'h1000_0000;
    #1;
    chk("mr_gnt1", 64'(bus.h_gnt_out), 64'h2);
    @(negedge clk_in);
    #1;
    chk("mr_gnt2", 64'(bus.h_gnt_out), 64'h4);
    chk("mr_rvalid", 64'(bus.h_rvalid_out), 64'h2);
    reset_n_in = 1'b0;
    #1;
    chk("mr_rst_gnt", 64'(bus.h_gnt_out), 64'h0);
    chk("mr_rst_dreq", 64'(bus.d_req_out), 64'h0);
    chk("mr_rst_rvalid", 64'(bus.h_rvalid_out), 64'h0);
    chk("mr_rst_rdata1", 64'(bus.h_rdata_out[1]), 64'h0);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    bus.h_req_in = 3'b111;
    #1;
    chk("post_rst_gnt", 64'(bus.h_gnt_out), 64'h1);
    chk("post_rst_rvalid", 64'(bus.h_rvalid_out), 64'h0);
    @(negedge clk_in);
    bus.h_req_in = 3'b000;
    #1;
    chk("post_rst_rvalid2", 64'(bus.h_rvalid_out), 64'h1);
    chk("post_rst_err", 64'(bus.h_err_out), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
